// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: controller state encoding and the IF/ID boundary record.
package fetch_ctrl_pkg;

  localparam int          FETCH_INSTR_W = 32;
  localparam logic [63:0] PC_STEP       = 64'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2,
    ST_OUT     = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic                     valid;
    logic [63:0]              pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: drives the PC update interface, issues one instruction
// request at a time, and presents fetched words to decode, absorbing redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        pc,
  output logic               pc_write,
  output logic [63:0]        pc_nxt,
  output logic               ireq_valid,
  output logic [63:0]        ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  output logic               if_valid,
  output logic [63:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_target
);

  fetch_state_t state_q, state_d;
  if_id_t       if_q, if_d;
  logic [63:0]  discard_addr_q, discard_addr_d;

  assign pc_nxt = redirect_valid ? redirect_target : (pc + PC_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      if_q           <= '0;
      discard_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      if_q           <= if_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    if_d           = if_q;
    discard_addr_d = discard_addr_q;
    pc_write       = 1'b0;
    ireq_valid     = 1'b0;
    ireq_addr      = pc;
    case (state_q)
      ST_IDLE: begin
        state_d  = ST_REQ;
        pc_write = redirect_valid;
      end
      ST_REQ: begin
        ireq_valid = 1'b1;
        ireq_addr  = pc;
        if (redirect_valid) begin
          // With data_ok the response is simply dropped; otherwise the old
          // request must be held at its original address until it returns.
          pc_write = 1'b1;
          if (iresp_data_ok) begin
            state_d = ST_REQ;
          end else begin
            discard_addr_d = pc;
            state_d        = ST_DISCARD;
          end
        end else if (iresp_data_ok) begin
          if_d.valid = 1'b1;
          if_d.pc    = pc;
          if_d.instr = iresp_data;
          pc_write   = 1'b1;
          state_d    = ST_OUT;
        end
      end
      ST_DISCARD: begin
        ireq_valid = 1'b1;
        ireq_addr  = discard_addr_q;
        if (redirect_valid) begin
          pc_write = 1'b1;
        end
        if (iresp_data_ok) begin
          state_d = ST_REQ;
        end
      end
      ST_OUT: begin
        if (redirect_valid) begin
          if_d.valid = 1'b0;
          pc_write   = 1'b1;
          state_d    = ST_REQ;
        end else if (id_ready) begin
          if_d.valid = 1'b0;
          state_d    = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign if_valid = if_q.valid;
  assign if_pc    = if_q.pc;
  assign if_instr = if_q.instr;

`ifndef SYNTHESIS
  // Shadow of the external PC register, used only to check it follows our writes.
  logic [63:0] pc_mirror_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_mirror_q <= RESET_PC;
    end else if (pc_write) begin
      pc_mirror_q <= pc_nxt;
    end
  end

  a_pc_mirror: assert property (@(posedge clk) disable iff (reset)
    pc == pc_mirror_q);

  a_resp_without_req: assert property (@(posedge clk) disable iff (reset)
    iresp_data_ok |-> ireq_valid);

  a_req_held: assert property (@(posedge clk) disable iff (reset)
    (ireq_valid && !iresp_data_ok) |=> (ireq_valid && $stable(ireq_addr)));

  a_if_held: assert property (@(posedge clk) disable iff (reset)
    (if_valid && !id_ready && !redirect_valid) |=>
      (if_valid && $stable(if_pc) && $stable(if_instr)));
`endif

endmodule
